intersection_scheduler: RTL and testbench

Phase scheduler for a two-approach intersection: main road A and side road B, plus a pedestrian crossing. It sequences green, yellow and all-red phases using programmable cycle-count timers. A-green is the rest phase; B and pedestrian service are granted on demand. Sits above the per-approach light drivers and below any system-level maintenance/config logic.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 24 ++
 rtl/intersection_scheduler.sv | 107 ++++++++++
 tb/tb_intersection_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp and phase types for the intersection scheduler.
// Also holds the state-to-lamp decode used for the registered outputs.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        ALL_RED_BA = 3'd0,
        A_GREEN    = 3'd1,
        A_YELLOW   = 3'd2,
        ALL_RED_AB = 3'd3,
        PED_WALK   = 3'd4,
        B_GREEN    = 3'd5,
        B_YELLOW   = 3'd6
    } sched_state_t;

    typedef struct packed {
        light_t a;
        light_t b;
        logic   walk;
    } lamps_t;

    // Anything not listed (incl. unused encodings) shows all-red, no walk.
    function automatic lamps_t lamps_of(sched_state_t s);
        lamps_t l;
        l.a    = RED;
        l.b    = RED;
        l.walk = 1'b0;
        case (s)
            A_GREEN:  l.a    = GREEN;
            A_YELLOW: l.a    = YELLOW;
            PED_WALK: l.walk = 1'b1;
            B_GREEN:  l.b    = GREEN;
            B_YELLOW: l.b    = YELLOW;
            default:  l.walk = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Time-in-phase counter: cleared on phase entry, counts up,
// and holds at MAX so long rest phases never wrap.
module phase_timer #(
    parameter int MAX = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    output logic [$clog2(MAX+1)-1:0]   count
);

    localparam int W = $clog2(MAX + 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != W'(MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Phase sequencer for main road A, side road B and a ped crossing.
// A-green is the rest phase; B and walk are served on demand.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 32,
    parameter int YELLOW_LEN  = 4,
    parameter int ALL_RED_LEN = 2,
    parameter int WALK_LEN    = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       car_b,
    input  logic       ped_req,
    output logic [1:0] light_a,
    output logic [1:0] light_b,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int CW = $clog2(GREEN_MAX + 1);

    sched_state_t    state;
    sched_state_t    state_nx;
    logic [CW-1:0]   cnt;
    logic            ped_pending;
    logic            entering;
    lamps_t          lamps_nx;

    assign entering = (state_nx != state);

    phase_timer #(
        .MAX(GREEN_MAX)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (entering),
        .count  (cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ALL_RED_BA;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ALL_RED_BA:
                if (cnt == CW'(ALL_RED_LEN - 1))
                    state_nx = A_GREEN;
            A_GREEN:
                if (cnt >= CW'(GREEN_MIN - 1) && (car_b || ped_pending))
                    state_nx = A_YELLOW;
            A_YELLOW:
                if (cnt == CW'(YELLOW_LEN - 1))
                    state_nx = ALL_RED_AB;
            ALL_RED_AB:
                if (cnt == CW'(ALL_RED_LEN - 1))
                    state_nx = ped_pending ? PED_WALK : B_GREEN;
            PED_WALK:
                if (cnt == CW'(WALK_LEN - 1))
                    state_nx = car_b ? B_GREEN : ALL_RED_BA;
            B_GREEN:
                if ((cnt >= CW'(GREEN_MIN - 1) && !car_b) ||
                    cnt == CW'(GREEN_MAX - 1))
                    state_nx = B_YELLOW;
            B_YELLOW:
                if (cnt == CW'(YELLOW_LEN - 1))
                    state_nx = ALL_RED_BA;
            default:
                state_nx = ALL_RED_BA;
        endcase
    end

    // Entering walk consumes the request, even one landing on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else if (entering && state_nx == PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req && state != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb lamps_nx = lamps_of(state_nx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            light_a <= RED;
            light_b <= RED;
            walk    <= 1'b0;
        end else begin
            light_a <= lamps_nx.a;
            light_b <= lamps_nx.b;
            walk    <= lamps_nx.walk;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler against a
// time-in-phase reference model; directed plus random traffic.
module tb_intersection_scheduler;

    localparam int GMIN = 8;
    localparam int GMAX = 32;
    localparam int YL   = 4;
    localparam int AR   = 2;
    localparam int WL   = 10;

    localparam int P_ARBA = 0;
    localparam int P_AG   = 1;
    localparam int P_AY   = 2;
    localparam int P_ARAB = 3;
    localparam int P_WALK = 4;
    localparam int P_BG   = 5;
    localparam int P_BY   = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       car_b = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] light_a;
    logic [1:0] light_b;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    int m_ph = P_ARBA;
    int m_t = 0;
    bit m_ped = 1'b0;

    intersection_scheduler #(
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_LEN (YL),
        .ALL_RED_LEN(AR),
        .WALK_LEN   (WL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .car_b  (car_b),
        .ped_req(ped_req),
        .light_a(light_a),
        .light_b(light_b),
        .walk   (walk),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expect_of(int ph);
        logic [4:0] l;
        case (ph)
            P_AG:    l = {2'b10, 2'b00, 1'b0};
            P_AY:    l = {2'b01, 2'b00, 1'b0};
            P_WALK:  l = {2'b00, 2'b00, 1'b1};
            P_BG:    l = {2'b00, 2'b10, 1'b0};
            P_BY:    l = {2'b00, 2'b01, 1'b0};
            default: l = 5'b0;
        endcase
        return {l, 3'(ph)};
    endfunction

    // Reference: how long each phase has lasted, judged by the rules.
    always @(posedge clk or negedge reset_n) begin : model
        int d;
        int np;
        bit nped;
        if (!reset_n) begin
            m_ph  <= P_ARBA;
            m_t   <= 0;
            m_ped <= 1'b0;
        end else begin
            d  = m_t + 1;
            np = m_ph;
            case (m_ph)
                P_ARBA: if (d >= AR) np = P_AG;
                P_AG:   if (d >= GMIN && (car_b || m_ped)) np = P_AY;
                P_AY:   if (d >= YL) np = P_ARAB;
                P_ARAB: if (d >= AR) np = m_ped ? P_WALK : P_BG;
                P_WALK: if (d >= WL) np = car_b ? P_BG : P_ARBA;
                P_BG:   if (d >= GMAX || (d >= GMIN && !car_b)) np = P_BY;
                P_BY:   if (d >= YL) np = P_ARBA;
                default: np = P_ARBA;
            endcase
            nped = m_ped;
            if (m_ph != P_WALK && ped_req) nped = 1'b1;
            if (np == P_WALK && m_ph != P_WALK) nped = 1'b0;
            m_ph  <= np;
            m_t   <= (np != m_ph) ? 0 : d;
            m_ped <= nped;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checks++;
            assert (!((light_a !== 2'b00 && light_b !== 2'b00) ||
                      (walk === 1'b1 && (light_a !== 2'b00 || light_b !== 2'b00))))
            else begin
                failures++;
                $display("FAIL safety: light_a=%b light_b=%b walk=%b",
                         light_a, light_b, walk);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        ped_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        car_b = 1'b0;
        apply_reset();
        checks++;
        if ({light_a, light_b, walk, phase} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got %b required 00000000",
                     {light_a, light_b, walk, phase});
        end
        tick();
        checks++;
        if ({light_a, light_b, walk} !== 5'b0) begin
            failures++;
            $display("FAIL reset_first_cycle: got %b required 00000",
                     {light_a, light_b, walk});
        end
        tick();
        checks++;
        if (light_a !== 2'b10) begin
            failures++;
            $display("FAIL reset_a_green_edge2: got %b required 10", light_a);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph) ||
                light_a !== 2'b10 || light_b !== 2'b00) begin
                failures++;
                $display("FAIL rest_a_green[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
        end
    endtask

    task automatic test_car_max;
        int ag;
        int ay;
        int bg;
        int by;
        int rr;
        bit done;
        ag = 0; ay = 0; bg = 0; by = 0; rr = 0;
        done = 1'b0;
        car_b = 1'b1;
        apply_reset();
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph)) begin
                failures++;
                $display("FAIL car_max_model[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
            if (by > 0 && light_a === 2'b10) done = 1'b1;
            else if (light_a === 2'b10) ag++;
            else if (light_a === 2'b01) ay++;
            else if (light_b === 2'b10) bg++;
            else if (light_b === 2'b01) by++;
            else rr++;
        end
        checks++;
        if (!done || ag != GMIN || ay != YL || bg != GMAX ||
            by != YL || rr != 2 * AR + 1) begin
            failures++;
            $display("FAIL car_max_lengths: ag=%0d ay=%0d bg=%0d by=%0d rr=%0d done=%0d required %0d %0d %0d %0d %0d 1",
                     ag, ay, bg, by, rr, done, GMIN, YL, GMAX, YL, 2 * AR + 1);
        end
    endtask

    task automatic test_car_pulse;
        int bg;
        bit back;
        bg = 0;
        back = 1'b0;
        car_b = 1'b0;
        apply_reset();
        for (int i = 0; i < 10 && light_a !== 2'b10; i++) tick();
        repeat (19) tick();
        car_b = 1'b1;
        tick();
        car_b = 1'b0;
        checks++;
        if (light_a !== 2'b01) begin
            failures++;
            $display("FAIL pulse_a_yellow: got %b required 01", light_a);
        end
        for (int i = 0; i < 100 && !back; i++) begin
            tick();
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph)) begin
                failures++;
                $display("FAIL pulse_model[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
            if (light_b === 2'b10) bg++;
            if (light_a === 2'b10) back = 1'b1;
        end
        checks++;
        if (bg != GMIN || !back) begin
            failures++;
            $display("FAIL pulse_b_green_len: got %0d back=%0d required %0d back=1",
                     bg, back, GMIN);
        end
    endtask

    task automatic test_ped_walk;
        int nw;
        int bg;
        bit walked;
        bit back;
        nw = 0; bg = 0;
        walked = 1'b0;
        back = 1'b0;
        car_b = 1'b0;
        apply_reset();
        for (int i = 0; i < 10 && light_a !== 2'b10; i++) tick();
        repeat (10) tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        for (int i = 0; i < 100 && !back; i++) begin
            tick();
            ped_req = 1'b0;
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph)) begin
                failures++;
                $display("FAIL ped_model[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
            if (walk === 1'b1) begin
                if (nw == 0) ped_req = 1'b1;
                nw++;
                walked = 1'b1;
            end
            if (light_b !== 2'b00) bg++;
            if (walked && light_a === 2'b10) back = 1'b1;
        end
        ped_req = 1'b0;
        checks++;
        if (nw != WL || bg != 0 || !back) begin
            failures++;
            $display("FAIL ped_walk_len: walk=%0d bgreen=%0d back=%0d required %0d 0 1",
                     nw, bg, back, WL);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (walk !== 1'b0 || light_a !== 2'b10) begin
                failures++;
                $display("FAIL ped_no_second_walk[%0d]: walk=%b light_a=%b required 0 10",
                         i, walk, light_a);
            end
        end
    endtask

    task automatic test_reset_mid;
        car_b = 1'b1;
        apply_reset();
        for (int i = 0; i < 60 && light_b !== 2'b10; i++) tick();
        checks++;
        if (light_b !== 2'b10) begin
            failures++;
            $display("FAIL mid_reach_b_green: got %b required 10", light_b);
        end
        repeat (5) tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        tick();
        car_b = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({light_a, light_b, walk, phase} !== 8'h00) begin
            failures++;
            $display("FAIL mid_async_reset: got %b required 00000000",
                     {light_a, light_b, walk, phase});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph)) begin
                failures++;
                $display("FAIL mid_restart[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
        end
        checks++;
        if (light_a !== 2'b10 || walk !== 1'b0) begin
            failures++;
            $display("FAIL mid_ped_cleared: light_a=%b walk=%b required 10 0",
                     light_a, walk);
        end
    endtask

    task automatic test_random;
        car_b = 1'b0;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) car_b = ~car_b;
            ped_req = ($urandom_range(0, 40) == 0);
            tick();
            checks++;
            if ({light_a, light_b, walk, phase} !== expect_of(m_ph)) begin
                failures++;
                $display("FAIL random[%0d]: got %b model %b", i,
                         {light_a, light_b, walk, phase}, expect_of(m_ph));
            end
        end
        ped_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_car_max();
        test_car_pulse();
        test_ped_walk();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
